// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - load/store responder with a fixed-latency BUSYWAIT handshake.
// Optional macro DMEM_CONFLICT_ERR_EN rejects simultaneous READ/WRITE with a one-cycle ERROR pulse.
module data_memory_responder #(
  parameter int ADDR_WIDTH     = 8,
  parameter int ACCESS_LATENCY = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [7:0]            WRITEDATA,
  output logic [7:0]            READDATA,
`ifdef DMEM_CONFLICT_ERR_EN
  output logic                  ERROR,
`endif
  output logic                  BUSYWAIT
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(ACCESS_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_wdata;
  logic                  r_is_write;
  logic [7:0]            r_readdata;
  logic                  r_busy;
  logic [7:0]            r_mem [DEPTH];
`ifdef DMEM_CONFLICT_ERR_EN
  logic                  r_error;
  logic                  w_conflict;

  assign w_conflict = READ & WRITE;
  assign ERROR      = r_error;
`endif

  assign READDATA = r_readdata;
  assign BUSYWAIT = r_busy;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= 8'h00;
      r_is_write <= 1'b0;
      r_readdata <= 8'h00;
      r_busy     <= 1'b0;
      r_mem      <= '{default: 8'h00};
`ifdef DMEM_CONFLICT_ERR_EN
      r_error    <= 1'b0;
`endif
    end else begin
`ifdef DMEM_CONFLICT_ERR_EN
      r_error <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
`ifdef DMEM_CONFLICT_ERR_EN
          if (w_conflict) begin
            r_error <= 1'b1;
          end else
`endif
          if (READ | WRITE) begin
            // WRITE wins when both are high
            r_addr     <= ADDRESS;
            r_wdata    <= WRITEDATA;
            r_is_write <= WRITE;
            r_cnt      <= LAT_M1;
            r_busy     <= 1'b1;
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (r_is_write) begin
              r_mem[r_addr] <= r_wdata;
            end else begin
              r_readdata <= r_mem[r_addr];
            end
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          // the CPU may still be holding the finished request here
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the CPU load/store interface. The ALU result serves as ADDRESS, and the CPU stalls on BUSYWAIT.
- Holds a 2^ADDR_WIDTH x 8-bit data store.
- Accepts one READ or WRITE request at a time, asserts BUSYWAIT for a fixed multi-cycle latency, then completes the access and returns to idle after a one-cycle turnaround.

Parameters:
- ADDR_WIDTH, 8, address bits; store depth = 2^ADDR_WIDTH words.
- ACCESS_LATENCY, 5, cycles BUSYWAIT stays high per access; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- READ  input  1  load request from CPU; held until BUSYWAIT falls.
- WRITE  input  1  store request from CPU; held until BUSYWAIT falls.
- ADDRESS  input  ADDR_WIDTH  word address (ALU result).
- WRITEDATA  input  8  store data.
- READDATA  output  8  load data; registered.
- BUSYWAIT  output  1  high while an access is in progress; registered.

Interface (already decided): one clock, CLK. Reset is RESET, synchronous and active-high.

Behaviour:
- Reset: at a rising CLK edge with RESET=1:
  - state=IDLE, counter=0, BUSYWAIT=0, READDATA=0.
  - All store words cleared to 8'h00.
  - RESET overrides every other input.
  - Reset mid-access aborts the access: no write is committed and READDATA is not updated.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - At edge R with READ|WRITE=1: latch ADDRESS, WRITEDATA and op (WRITE has priority if both are high).
  - Load counter = ACCESS_LATENCY-1, set BUSYWAIT=1, go to ACCESS.
  - Otherwise hold; BUSYWAIT stays 0.
- ACCESS:
  - Each edge with counter!=0: decrement counter.
  - At the edge with counter==0 (edge R+ACCESS_LATENCY):
    - Write op: mem[addr_l] <= wdata_l.
    - Read op: READDATA <= mem[addr_l].
    - BUSYWAIT <= 0; go to DONE.
  - Input changes on ADDRESS, WRITEDATA, READ or WRITE during ACCESS are ignored; the latched copies are used.
- DONE:
  - One turnaround cycle; requests are ignored (the CPU still holds the old request here). Go to IDLE.
  - Earliest next acceptance is edge R+ACCESS_LATENCY+2.
- Timing: BUSYWAIT is high for exactly ACCESS_LATENCY cycles per access. READDATA is valid in the first cycle BUSYWAIT is low and holds until the next read completion or reset.
- Write-then-read to the same address returns the new data; there is no bypass requirement, since accesses are serialised.
- ACCESS_LATENCY=1: BUSYWAIT high for one cycle; completion at the edge after acceptance.
- Address wrap: none. ADDRESS is exactly ADDR_WIDTH bits and every value maps to a word.
- No X propagation: READDATA never shows uninitialised data after reset.

Optional Feature:
- Macro: DMEM_CONFLICT_ERR_EN.
- Defined:
  - Adds output ERROR (1 bit, reset 0).
  - READ=1 and WRITE=1 sampled together in IDLE → request rejected: no latch, BUSYWAIT stays 0, ERROR=1 for exactly one cycle, state stays IDLE.
  - ERROR is never asserted otherwise.
- Undefined: ERROR port absent; simultaneous READ and WRITE is treated as a write (normal ACCESS sequence).

Test Plan:
- Reset then read: RESET one edge, then READ addr 8'h10 → BUSYWAIT high 5 cycles, READDATA=8'h00 when it falls, ERROR=0.
- Store/load round trip: WRITE addr 8'h2A data 8'hC3 (hold until BUSYWAIT low), then READ 8'h2A → READDATA=8'hC3. Next accept no earlier than 2 edges after completion.
- Back-to-back held request: keep READ=1 through DONE → exactly one access per request. A second access starts only when the request is resampled in IDLE; the DONE edge is ignored.
- Mid-access input change: READ addr 8'h05 (mem=8'h11); switch ADDRESS to 8'h06 (mem=8'h22) during ACCESS → READDATA=8'h11.
- Reset mid-write: WRITE addr 8'h07 data 8'hFF, assert RESET at cycle 3 of BUSYWAIT → BUSYWAIT=0 next cycle; later READ 8'h07 returns 8'h00.
- Conflict (macro on / off): READ=WRITE=1, addr 8'h01, data 8'h5A:
  - On → ERROR pulses 1 cycle, BUSYWAIT stays 0, mem[1] unchanged.
  - Off → write completes, mem[1]=8'h5A.
